// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the convolutional encoder / Viterbi decoder link:
// constraint length, generator polynomials, encoder FSM states and the parity helper.
package viterbi_pkg;

  localparam int K = 4;

  // Bit K-1 of each generator taps the current input bit.
  localparam logic [K-1:0] G0 = 4'b1101;
  localparam logic [K-1:0] G1 = 4'b1111;

  typedef enum logic {
    ST_DATA,
    ST_TAIL
  } enc_state_e;

  function automatic logic conv_parity(input logic [K-1:0] w, input logic [K-1:0] g);
    return ^(w & g);
  endfunction

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2, K=4 convolutional encoder that frames FRAME_LEN information bits and
// appends K-1 zero tail bits so the decoder's trellis always restarts from state 0.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] Tx,
  output logic       seqrdy,
  input  logic       tx_ready,
  output logic       sof,
  output logic       eof
);

  // The counter serves both phases, so it must also reach K-2 when FRAME_LEN is tiny.
  localparam int DATA_W = $clog2(FRAME_LEN + 1);
  localparam int TAIL_W = $clog2(K);
  localparam int CNT_W  = (DATA_W > TAIL_W) ? DATA_W : TAIL_W;

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(K - 2);

  enc_state_e       state_q, state_d;
  logic [K-2:0]     sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tx_q, tx_d;
  logic             seqrdy_q, seqrdy_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic             out_free;
  logic             advance;
  logic             enc_bit;
  logic [K-1:0]     window;

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    out_free  = !seqrdy_q || tx_ready;
    din_ready = (state_q == ST_DATA) && out_free;
    enc_bit   = (state_q == ST_DATA) ? din : 1'b0;
    window    = {enc_bit, sr_q};

    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    seqrdy_d = seqrdy_q;
    sof_d    = sof_q;
    eof_d    = eof_q;
    advance  = 1'b0;

    unique case (state_q)
      ST_DATA: begin
        if (din_valid && din_ready) begin
          advance = 1'b1;
          sof_d   = (cnt_q == '0);
          eof_d   = 1'b0;
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = ST_TAIL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_TAIL: begin
        // Tail bits are self-timed: they only wait for room at the output.
        if (out_free) begin
          advance = 1'b1;
          sof_d   = 1'b0;
          eof_d   = (cnt_q == LAST_TAIL);
          if (cnt_q == LAST_TAIL) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase

    if (advance) begin
      tx_d     = {conv_parity(window, G0), conv_parity(window, G1)};
      sr_d     = window[K-1:1];
      seqrdy_d = 1'b1;
    end else if (out_free) begin
      seqrdy_d = 1'b0;
      sof_d    = 1'b0;
      eof_d    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_DATA;
      sr_q     <= '0;
      cnt_q    <= '0;
      tx_q     <= 2'b00;
      seqrdy_q <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      seqrdy_q <= seqrdy_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
    end
  end

  assign Tx     = tx_q;
  assign seqrdy = seqrdy_q;
  assign sof    = sof_q;
  assign eof    = eof_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: a FRAME_LEN=1 instance for the impulse response and
// a FRAME_LEN=16 instance checked symbol-by-symbol against a scoreboard model.
module tb_conv_encoder;

  localparam int FL_B = 16;

  typedef struct packed {
    logic [1:0] tx;
    logic       sof;
    logic       eof;
  } sym_t;

  logic clock, reset;

  logic       din_a, valid_a, ready_a, seqrdy_a, tx_ready_a, sof_a, eof_a;
  logic [1:0] tx_a;
  logic       din_b, valid_b, ready_b, seqrdy_b, tx_ready_b, sof_b, eof_b;
  logic [1:0] tx_b;

  conv_encoder #(.FRAME_LEN(1)) dut_a (
    .clock(clock), .reset(reset), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .Tx(tx_a), .seqrdy(seqrdy_a), .tx_ready(tx_ready_a), .sof(sof_a), .eof(eof_a)
  );

  conv_encoder #(.FRAME_LEN(FL_B)) dut_b (
    .clock(clock), .reset(reset), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .Tx(tx_b), .seqrdy(seqrdy_b), .tx_ready(tx_ready_b), .sof(sof_b), .eof(eof_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: G0 taps {b, s2, s0}, G1 taps {b, s2, s1, s0}; s2 is the newest bit.
  sym_t       exp_q[$];
  logic [2:0] model_sr;
  int         model_cnt;
  int         n_pop;
  int         run_len, max_run;

  function automatic sym_t model_enc(input logic b, input logic s, input logic e);
    sym_t r;
    r.tx  = {b ^ model_sr[2] ^ model_sr[0], b ^ model_sr[2] ^ model_sr[1] ^ model_sr[0]};
    r.sof = s;
    r.eof = e;
    model_sr = {b, model_sr[2:1]};
    return r;
  endfunction

  task automatic model_push(input logic b);
    exp_q.push_back(model_enc(b, model_cnt == 0, 1'b0));
    model_cnt++;
    if (model_cnt == FL_B) begin
      model_cnt = 0;
      for (int t = 0; t < 3; t++) exp_q.push_back(model_enc(1'b0, 1'b0, t == 2));
    end
  endtask

  // Scoreboard for dut_b: consumption and acceptance both happen at the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (seqrdy_b && tx_ready_b) begin
        n_pop++;
        if (exp_q.size() == 0) check("unexpected_sym", {tx_b, sof_b, eof_b}, 32'hFF);
        else check("sym", {tx_b, sof_b, eof_b}, exp_q.pop_front());
      end
      if (valid_b && ready_b) model_push(din_b);
      run_len = seqrdy_b ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  task automatic push_bit(input logic b, output int waited);
    waited = 0;
    din_b = b;
    valid_b = 1'b1;
    forever begin
      @(negedge clock);
      if (ready_b) break;
      waited++;
      if (waited > 60) begin
        check("accept_wait", ready_b, 1'b1);
        break;
      end
    end
    @(posedge clock); #1;
    valid_b = 1'b0;
  endtask

  task automatic drain_b(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
    check({tag, "_idle"}, seqrdy_b, 1'b0);
  endtask

  task automatic send_frame_b(input logic [15:0] bits, input int stall_after, output int first_wait);
    int w;
    first_wait = 0;
    for (int i = 0; i < FL_B; i++) begin
      push_bit(bits[i], w);
      if (i == 0) first_wait = w;
      if (i == stall_after) begin
        logic [4:0] held;
        tx_ready_b = 1'b0;
        held = {tx_b, sof_b, eof_b, seqrdy_b};
        for (int s = 0; s < 5; s++) begin
          @(negedge clock);
          check("stall_hold", {tx_b, sof_b, eof_b, seqrdy_b}, held);
          check("stall_seqrdy", seqrdy_b, 1'b1);
          check("stall_din_ready", ready_b, 1'b0);
          @(posedge clock); #1;
        end
        tx_ready_b = 1'b1;
      end
    end
  endtask

  logic [1:0] imp_tx [4];
  int         gap;

  initial begin
    imp_tx = '{2'b11, 2'b11, 2'b01, 2'b11};
    reset = 1'b1;
    din_a = 0; valid_a = 0; tx_ready_a = 0;
    din_b = 0; valid_b = 0; tx_ready_b = 0;
    model_sr = '0; model_cnt = 0; n_pop = 0; run_len = 0; max_run = 0;

    #12;
    check("rst_tx", tx_b, 2'b00);
    check("rst_seqrdy", seqrdy_b, 1'b0);
    check("rst_sof", sof_b, 1'b0);
    check("rst_eof", eof_b, 1'b0);
    check("rst_din_ready", ready_b, 1'b1);
    check("rst_din_ready_a", ready_a, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;

    // Impulse response with FRAME_LEN=1.
    tx_ready_a = 1'b1;
    din_a = 1'b1; valid_a = 1'b1;
    #1 check("imp_din_ready", ready_a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      valid_a = 1'b0;
      check("imp_tx", tx_a, imp_tx[i]);
      check("imp_seqrdy", seqrdy_a, 1'b1);
      check("imp_sof", sof_a, i == 0);
      check("imp_eof", eof_a, i == 3);
      if (i < 3) check("imp_tail_din_ready", ready_a, 1'b0);
    end
    check("imp_back_ready", ready_a, 1'b1);
    // A zero frame right after the tail only yields 00 if the register flushed to 0.
    din_a = 1'b0; valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      valid_a = 1'b0;
      check("flush_tx", tx_a, 2'b00);
      check("flush_sof", sof_a, i == 0);
      check("flush_eof", eof_a, i == 3);
    end
    @(posedge clock); #1;
    check("imp_idle", seqrdy_a, 1'b0);

    // All-zero frame: 19 symbols of 00, sof first, eof last.
    tx_ready_b = 1'b1;
    n_pop = 0;
    send_frame_b(16'h0000, -1, gap);
    drain_b("zero");
    check("zero_sym_count", n_pop, FL_B + 3);

    // Stall of 5 cycles after the sixth bit.
    send_frame_b(16'b1100_0011_0010_1101, 5, gap);
    drain_b("stall");

    // Back-to-back frames with din_valid held high.
    max_run = 0;
    send_frame_b(16'hA5F0, -1, gap);
    send_frame_b(16'h3C96, -1, gap);
    check("b2b_gap", gap, 3);
    drain_b("b2b");
    check("b2b_run", max_run, 2 * (FL_B + 3));

    // Asynchronous reset after 7 bits, then a clean frame.
    for (int i = 0; i < 7; i++) push_bit(i[0], gap);
    check("pre_reset_seqrdy", seqrdy_b, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tx", tx_b, 2'b00);
    check("mid_rst_seqrdy", seqrdy_b, 1'b0);
    check("mid_rst_sof", sof_b, 1'b0);
    check("mid_rst_eof", eof_b, 1'b0);
    check("mid_rst_din_ready", ready_b, 1'b1);
    exp_q.delete();
    model_sr = '0;
    model_cnt = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    send_frame_b(16'h6D2B, -1, gap);
    drain_b("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
